// File: rtl/io_resp_pkg.sv
// Shared constants and types for the I/O bus responder: register offsets,
// CTRL/STAT bit positions, the bus FSM state encoding and the compare reset value.
package io_resp_pkg;

  localparam logic [2:0] REG_SW     = 3'd0;
  localparam logic [2:0] REG_LED    = 3'd1;
  localparam logic [2:0] REG_TMR_LO = 3'd2;
  localparam logic [2:0] REG_TMR_HI = 3'd3;
  localparam logic [2:0] REG_CMP_LO = 3'd4;
  localparam logic [2:0] REG_CMP_HI = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STAT   = 3'd7;

  localparam int CTRL_TEN     = 0;
  localparam int CTRL_IEN     = 1;
  localparam int CTRL_AUTOCLR = 2;
  localparam int STAT_MATCH   = 0;

  localparam logic [15:0] CMP_RESET = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_e;

endpackage

// File: rtl/io_timer.sv
// Free-running timer with compare match, sticky MATCH flag (W1C, set wins) and
// optional power-of-two prescaler enabled by the IO_PRESCALER_EN macro.
module io_timer
  import io_resp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ten,
  input  logic             autoclr,
`ifdef IO_PRESCALER_EN
  input  logic [3:0]       psc_sel,
`endif
  input  logic             cmp_lo_we,
  input  logic             cmp_hi_we,
  input  logic [7:0]       wdata,
  input  logic             match_clr,
  output logic [WIDTH-1:0] timer,
  output logic [WIDTH-1:0] compare,
  output logic             match_flag
);

  logic             tick_s;
  logic             match_s;
  logic [WIDTH-1:0] timer_r;
  logic [WIDTH-1:0] cmp_r;
  logic             match_r;

`ifdef IO_PRESCALER_EN
  logic [14:0] psc_r;
  logic [14:0] psc_mask_s;

  // Tick once the low P bits of the prescale counter are all ones (every 2^P clocks).
  always_comb begin
    psc_mask_s = 15'((16'd1 << psc_sel) - 16'd1);
    tick_s     = ((psc_r & psc_mask_s) == psc_mask_s);
  end

  // Prescale counter runs only while the timer is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_r <= 15'd0;
    end else if (!ten) begin
      psc_r <= 15'd0;
    end else begin
      psc_r <= psc_r + 15'd1;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Match is qualified by the tick so a prescaled timer matches once per value.
  assign match_s = ten & tick_s & (timer_r == cmp_r);

  // Timer counts on each tick; AUTOCLR reloads zero on the match tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else if (ten && tick_s) begin
      timer_r <= (match_s && autoclr) ? WIDTH'(0) : timer_r + WIDTH'(1);
    end
  end

  // Compare register byte writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_r <= WIDTH'(CMP_RESET);
    end else begin
      if (cmp_lo_we) cmp_r[7:0]  <= wdata;
      if (cmp_hi_we) cmp_r[15:8] <= wdata;
    end
  end

  // Sticky match flag; a new match beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_r <= 1'b0;
    end else if (match_s) begin
      match_r <= 1'b1;
    end else if (match_clr) begin
      match_r <= 1'b0;
    end
  end

  assign timer      = timer_r;
  assign compare    = cmp_r;
  assign match_flag = match_r;

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: window decode, wait-state handshake FSM, LED/CTRL
// registers, switch synchroniser and timer. Optional prescaler: IO_PRESCALER_EN.
module io_bus_responder
  import io_resp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMER_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        bus_ready,
  input  logic [3:0]  switches_in,
  output logic [7:0]  leds_out,
  output logic        irq_n
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  bus_state_e             state_r, state_nx_s;
  logic [3:0]             wait_r, wait_nx_s;
  logic [2:0]             off_s;
  logic                   hit_s, req_s, ack_nx_s, rd_nx_s, wr_s;
  logic [3:0]             sw_meta_r, sw_sync_r;
  logic [7:0]             leds_r, snap_r, rdata_r, rd_mux_s;
  logic [6:0]             ctrl_r;
  logic                   ready_r, irq_n_r, match_s;
  logic [TIMER_WIDTH-1:0] timer_s, cmp_s;

  assign off_s    = bus_addr[2:0];
  assign hit_s    = (bus_addr[15:3] == BASE_ADDR[15:3]);
  assign req_s    = bus_read | bus_write;
  assign ack_nx_s = (state_nx_s == ST_ACK);
  assign rd_nx_s  = ack_nx_s & ~bus_write;
  assign wr_s     = (state_r == ST_ACK) & bus_write;

  // Next-state logic for the request/ready handshake.
  always_comb begin
    state_nx_s = state_r;
    wait_nx_s  = wait_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s && hit_s) begin
          state_nx_s = NO_WAIT ? ST_ACK : ST_WAIT;
          wait_nx_s  = 4'd1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!(req_s && hit_s)) begin
          state_nx_s = ST_IDLE;
        end else if (wait_r == WAIT_LAST) begin
          state_nx_s = ST_ACK;
        end else begin
          wait_nx_s = wait_r + 4'd1;
        end
      end
      ST_ACK:  state_nx_s = ST_HOLD;
      ST_HOLD: begin
        if (!req_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Read mux of current register contents.
  always_comb begin
    rd_mux_s = 8'h00;
    case (off_s)
      REG_SW:     rd_mux_s = {4'h0, sw_sync_r};
      REG_LED:    rd_mux_s = leds_r;
      REG_TMR_LO: rd_mux_s = timer_s[7:0];
      REG_TMR_HI: rd_mux_s = snap_r;
      REG_CMP_LO: rd_mux_s = cmp_s[7:0];
      REG_CMP_HI: rd_mux_s = cmp_s[15:8];
      REG_CTRL:   rd_mux_s = {1'b0, ctrl_r};
      REG_STAT:   rd_mux_s = {7'b0, match_s};
      default:    rd_mux_s = 8'h00;
    endcase
  end

  // FSM state, ready strobe and read data; the snapshot is latched with the low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      wait_r  <= 4'd0;
      ready_r <= 1'b0;
      rdata_r <= 8'h00;
      snap_r  <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      wait_r  <= wait_nx_s;
      ready_r <= ack_nx_s;
      rdata_r <= rd_nx_s ? rd_mux_s : 8'h00;
      if (rd_nx_s && (off_s == REG_TMR_LO)) snap_r <= timer_s[15:8];
    end
  end

  // Writable registers commit at the end of the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_r <= 8'h00;
      ctrl_r <= 7'd0;
    end else if (wr_s) begin
      if (off_s == REG_LED) leds_r <= bus_wdata;
`ifdef IO_PRESCALER_EN
      if (off_s == REG_CTRL) ctrl_r <= bus_wdata[6:0];
`else
      if (off_s == REG_CTRL) ctrl_r <= {4'b0000, bus_wdata[2:0]};
`endif
    end
  end

  // Two-flop switch synchroniser and registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r <= 4'h0;
      sw_sync_r <= 4'h0;
      irq_n_r   <= 1'b1;
    end else begin
      sw_meta_r <= switches_in;
      sw_sync_r <= sw_meta_r;
      irq_n_r   <= ~(match_s & ctrl_r[CTRL_IEN]);
    end
  end

  io_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ten        (ctrl_r[CTRL_TEN]),
    .autoclr    (ctrl_r[CTRL_AUTOCLR]),
`ifdef IO_PRESCALER_EN
    .psc_sel    (ctrl_r[6:3]),
`endif
    .cmp_lo_we  (wr_s && (off_s == REG_CMP_LO)),
    .cmp_hi_we  (wr_s && (off_s == REG_CMP_HI)),
    .wdata      (bus_wdata),
    .match_clr  (wr_s && (off_s == REG_STAT) && bus_wdata[STAT_MATCH]),
    .timer      (timer_s),
    .compare    (cmp_s),
    .match_flag (match_s)
  );

  assign bus_ready = ready_r;
  assign bus_rdata = rdata_r;
  assign leds_out  = leds_r;
  assign irq_n     = irq_n_r;

endmodule
